// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing generator: qualifies PLL lock, then runs the
// pixel/line counters and emits registered syncs, coordinates and strobes.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit H_POL     = 1'b0,
  parameter bit V_POL     = 1'b0,
  parameter int LOCK_WAIT = 16,
  parameter int COORD_W   = 10
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               pll_locked_i,
  output logic               running_o,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               active_o,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               line_start_o,
  output logic               frame_start_o,
  output logic [7:0]         frame_count_o
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int LOCK_W  = $clog2(LOCK_WAIT + 1);

  typedef logic [COORD_W-1:0] coord_t;

  localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS      = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS      = coord_t'(V_VISIBLE);
  localparam coord_t H_SYNC_BEG = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t H_SYNC_END = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t V_SYNC_BEG = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t V_SYNC_END = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_WAIT - 1);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t              state_q, state_d;
  logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
  coord_t              x_q, x_d;
  coord_t              y_q, y_d;
  logic [7:0]          fc_q, fc_d;
  logic                run_q, run_d;
  logic                hsync_q, hsync_d;
  logic                vsync_q, vsync_d;
  logic                active_q, active_d;
  logic                ls_q, ls_d;
  logic                fs_q, fs_d;

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    x_d        = x_q;
    y_d        = y_q;
    fc_d       = fc_q;
    run_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        x_d  = '0;
        y_d  = '0;
        fc_d = '0;
        if (!pll_locked_i) begin
          lock_cnt_d = '0;
        end else if (lock_cnt_q == LOCK_LAST) begin
          // Qualifying edge: first running cycle already shows pixel (0,0).
          state_d    = ST_RUN;
          lock_cnt_d = '0;
          run_d      = 1'b1;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!pll_locked_i) begin
          state_d    = ST_IDLE;
          lock_cnt_d = '0;
          x_d        = '0;
          y_d        = '0;
          fc_d       = '0;
        end else begin
          run_d = 1'b1;
          if (x_q == H_LAST) begin
            x_d = '0;
            if (y_q == V_LAST) begin
              y_d  = '0;
              fc_d = fc_q + 8'd1;
            end else begin
              y_d = y_q + 1'b1;
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Decode from the next coordinates so every output lines up with x/y.
    hsync_d  = (run_d && x_d >= H_SYNC_BEG && x_d < H_SYNC_END) ? H_POL : ~H_POL;
    vsync_d  = (run_d && y_d >= V_SYNC_BEG && y_d < V_SYNC_END) ? V_POL : ~V_POL;
    active_d = run_d && (x_d < H_VIS) && (y_d < V_VIS);
    ls_d     = run_d && (x_d == '0);
    fs_d     = ls_d && (y_d == '0);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      lock_cnt_q <= '0;
      x_q        <= '0;
      y_q        <= '0;
      fc_q       <= '0;
      run_q      <= 1'b0;
      hsync_q    <= ~H_POL;
      vsync_q    <= ~V_POL;
      active_q   <= 1'b0;
      ls_q       <= 1'b0;
      fs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      x_q        <= x_d;
      y_q        <= y_d;
      fc_q       <= fc_d;
      run_q      <= run_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      active_q   <= active_d;
      ls_q       <= ls_d;
      fs_q       <= fs_d;
    end
  end

  assign running_o     = run_q;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign active_o      = active_q;
  assign x_o           = x_q;
  assign y_o           = y_q;
  assign line_start_o  = ls_q;
  assign frame_start_o = fs_q;
  assign frame_count_o = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full 640x480 instance for lock/line/unlock/reset behaviour,
// small-parameter instance for frame timing and frame_count wrap.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // full-size instance
  logic       rst_f, lock_f;
  logic       run_f, hs_f, vs_f, act_f, ls_f, fs_f;
  logic [9:0] x_f, y_f;
  logic [7:0] fc_f;

  // small instance
  logic       rst_s, lock_s;
  logic       run_s, hs_s, vs_s, act_s, ls_s, fs_s;
  logic [3:0] x_s, y_s;
  logic [7:0] fc_s;

  vga_timing_gen u_full (
    .clock_i(clk), .reset_i(rst_f), .pll_locked_i(lock_f),
    .running_o(run_f), .hsync_o(hs_f), .vsync_o(vs_f), .active_o(act_f),
    .x_o(x_f), .y_o(y_f), .line_start_o(ls_f), .frame_start_o(fs_f),
    .frame_count_o(fc_f)
  );

  vga_timing_gen #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .LOCK_WAIT(1), .COORD_W(4)
  ) u_small (
    .clock_i(clk), .reset_i(rst_s), .pll_locked_i(lock_s),
    .running_o(run_s), .hsync_o(hs_s), .vsync_o(vs_s), .active_o(act_s),
    .x_o(x_s), .y_o(y_s), .line_start_o(ls_s), .frame_start_o(fs_s),
    .frame_count_o(fc_s)
  );

  int checks = 0;
  int errors = 0;
  int n, ex, ey, efc;
  int hs_low, hs_first, act_cnt, ls_cnt, vs_low, xy_err;
  int e_xy, e_hs, e_vs, e_act, e_str, e_run;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle_full(input string tag);
    check({tag, "_running"}, 32'(run_f), 32'd0);
    check({tag, "_x"},       32'(x_f),   32'd0);
    check({tag, "_y"},       32'(y_f),   32'd0);
    check({tag, "_hsync"},   32'(hs_f),  32'd1);
    check({tag, "_vsync"},   32'(vs_f),  32'd1);
    check({tag, "_active"},  32'(act_f), 32'd0);
    check({tag, "_ls"},      32'(ls_f),  32'd0);
    check({tag, "_fs"},      32'(fs_f),  32'd0);
    check({tag, "_fc"},      32'(fc_f),  32'd0);
  endtask

  task automatic wait_running_full(input string tag);
    n = 0;
    while (!run_f && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_lock_edges"}, 32'(n), 32'd16);
    check({tag, "_x0"},     32'(x_f),   32'd0);
    check({tag, "_y0"},     32'(y_f),   32'd0);
    check({tag, "_active"}, 32'(act_f), 32'd1);
    check({tag, "_fs"},     32'(fs_f),  32'd1);
    check({tag, "_ls"},     32'(ls_f),  32'd1);
    check({tag, "_hsync"},  32'(hs_f),  32'd1);
    check({tag, "_vsync"},  32'(vs_f),  32'd1);
    check({tag, "_fc"},     32'(fc_f),  32'd0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_f = 1'b1; lock_f = 1'b1;
    rst_s = 1'b1; lock_s = 1'b1;
    tick();
    tick();
    check_idle_full("reset");

    // lock qualification from reset release
    rst_f = 1'b0;
    wait_running_full("start");

    // one full line plus the first cycle of the next
    hs_low = 0; hs_first = -1; act_cnt = 0; ls_cnt = 0; vs_low = 0; xy_err = 0;
    for (int i = 0; i < 800; i++) begin
      if (!hs_f) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(x_f);
      end
      if (act_f) act_cnt++;
      if (ls_f) ls_cnt++;
      if (!vs_f) vs_low++;
      if (int'(x_f) != i || y_f != 10'd0) xy_err++;
      tick();
    end
    check("line_hs_low",   32'(hs_low),   32'd96);
    check("line_hs_first", 32'(hs_first), 32'd656);
    check("line_active",   32'(act_cnt),  32'd640);
    check("line_ls_count", 32'(ls_cnt),   32'd1);
    check("line_vs_low",   32'(vs_low),   32'd0);
    check("line_xy",       32'(xy_err),   32'd0);
    check("line2_x",  32'(x_f),  32'd0);
    check("line2_y",  32'(y_f),  32'd1);
    check("line2_ls", 32'(ls_f), 32'd1);
    check("line2_fs", 32'(fs_f), 32'd0);

    // lock drop mid-line
    for (int i = 0; i < 100; i++) tick();
    check("unlock_pre_x", 32'(x_f), 32'd100);
    check("unlock_pre_y", 32'(y_f), 32'd1);
    lock_f = 1'b0;
    tick();
    check_idle_full("unlock");
    lock_f = 1'b1;
    wait_running_full("relock");

    // reset pulse mid-line
    for (int i = 0; i < 700; i++) tick();
    check("rst_pre_x", 32'(x_f), 32'd700);
    rst_f = 1'b1;
    tick();
    check_idle_full("midrst");
    tick();
    check("midrst_hold_running", 32'(run_f), 32'd0);
    rst_f = 1'b0;
    wait_running_full("restart");

    // small instance: LOCK_WAIT=1, 8x6 raster, 48 cycles per frame
    rst_s = 1'b0;
    tick();
    check("s_start_running", 32'(run_s), 32'd1);
    check("s_start_fs",      32'(fs_s),  32'd1);
    check("s_start_x",       32'(x_s),   32'd0);
    check("s_start_fc",      32'(fc_s),  32'd0);

    ex = 0; ey = 0; efc = 0;
    e_xy = 0; e_hs = 0; e_vs = 0; e_act = 0; e_str = 0; e_run = 0;
    hs_low = 0; vs_low = 0; ls_cnt = 0;
    for (int cyc = 0; cyc < 256 * 48; cyc++) begin
      if (int'(x_s) != ex || int'(y_s) != ey || int'(fc_s) != efc) e_xy++;
      if (hs_s != !(ex >= 5 && ex < 7)) e_hs++;
      if (vs_s != (ey != 4)) e_vs++;
      if (act_s != (ex < 4 && ey < 3)) e_act++;
      if (ls_s != (ex == 0) || fs_s != (ex == 0 && ey == 0)) e_str++;
      if (!run_s) e_run++;
      if (cyc < 48) begin
        if (!hs_s) hs_low++;
        if (!vs_s) vs_low++;
        if (fs_s) ls_cnt++;
      end
      if (cyc == 48) check("s_fc_first", 32'(fc_s), 32'd1);
      if (cyc == 255 * 48) check("s_fc_255", 32'(fc_s), 32'd255);
      tick();
      if (ex == 7) begin
        ex = 0;
        if (ey == 5) begin
          ey = 0;
          efc = (efc + 1) % 256;
        end else begin
          ey++;
        end
      end else begin
        ex++;
      end
    end
    check("s_xy_fc",    32'(e_xy),  32'd0);
    check("s_hsync",    32'(e_hs),  32'd0);
    check("s_vsync",    32'(e_vs),  32'd0);
    check("s_active",   32'(e_act), 32'd0);
    check("s_strobes",  32'(e_str), 32'd0);
    check("s_running",  32'(e_run), 32'd0);
    check("s_hs_low_f0", 32'(hs_low), 32'd12);
    check("s_vs_low_f0", 32'(vs_low), 32'd8);
    check("s_fs_per_frame", 32'(ls_cnt), 32'd1);
    check("s_fc_wrap",  32'(fc_s), 32'd0);
    check("s_wrap_fs",  32'(fs_s), 32'd1);

    // small instance lock drop clears frame_count
    for (int i = 0; i < 60; i++) tick();
    check("s_fc_before_unlock", 32'(fc_s), 32'd1);
    lock_s = 1'b0;
    tick();
    check("s_unlock_running", 32'(run_s), 32'd0);
    check("s_unlock_fc",      32'(fc_s),  32'd0);
    check("s_unlock_vsync",   32'(vs_s),  32'd1);
    lock_s = 1'b1;
    tick();
    check("s_relock_running", 32'(run_s), 32'd1);
    check("s_relock_fs",      32'(fs_s),  32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
